// File: rtl/error_line_buffer_if.sv
// Pixel-side bus of the row-to-row error store: line control, kernel error
// writes and the previous-row error read back for the current column.
interface error_line_buffer_if #(
    parameter int ERROR_BITS = 9,
    parameter int ADDR_BITS  = 11
);
    logic                         frame_start;
    logic                         line_start;
    logic        [ADDR_BITS-1:0]  line_width;
    logic                         pix_valid;
    logic signed [ERROR_BITS-1:0] err_bl_wr;
    logic signed [ERROR_BITS-1:0] err_b_wr;
    logic signed [ERROR_BITS-1:0] err_rd;
    logic                         ready;
    logic                         line_done;

    modport master (
        output frame_start, line_start, line_width, pix_valid, err_bl_wr, err_b_wr,
        input  err_rd, ready, line_done
    );

    modport slave (
        input  frame_start, line_start, line_width, pix_valid, err_bl_wr, err_b_wr,
        output err_rd, ready, line_done
    );
endinterface

// File: rtl/error_line_buffer.sv
// Single-RAM line buffer holding the bottom-row errors of row y and returning
// them one column ahead for row y+1, updated in place one pixel behind the read.
module error_line_buffer #(
    parameter int ERROR_BITS = 9,
    parameter int MAX_WIDTH  = 2048,
    parameter int ADDR_BITS  = 11
) (
    input  logic               clk,
    input  logic               rst,
    error_line_buffer_if.slave bus
);
    typedef logic signed [ERROR_BITS-1:0] err_t;
    typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] col, width_q, last_col, width_clip;
    logic                 first_line;
    err_t                 b_last;

    err_t                 mem [MAX_WIDTH];
    err_t                 rd_data_p1, hold_p2;
    logic                 fresh_p1;

    logic                 start_ok, take_pix;
    logic                 rd_en, wr_en;
    logic [ADDR_BITS-1:0] rd_addr, wr_addr;
    err_t                 wr_data;

    assign last_col   = width_q - ADDR_BITS'(1);
    assign width_clip = (int'(bus.line_width) > MAX_WIDTH) ? ADDR_BITS'(MAX_WIDTH) : bus.line_width;
    assign start_ok   = bus.line_start && (bus.line_width != '0);
    // A line_start or frame_start in the same cycle as a pixel kills that pixel's write.
    assign take_pix   = (state == ACTIVE) && bus.pix_valid && !bus.line_start && !bus.frame_start;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.frame_start) begin
            state_nxt = start_ok ? PREFETCH : IDLE;
        end else begin
            case (state)
                IDLE:     if (start_ok) state_nxt = PREFETCH;
                PREFETCH: state_nxt = bus.line_start ? (start_ok ? PREFETCH : IDLE) : ACTIVE;
                ACTIVE: begin
                    if (bus.line_start)                    state_nxt = start_ok ? PREFETCH : IDLE;
                    else if (take_pix && col == last_col)  state_nxt = FLUSH;
                end
                FLUSH:    state_nxt = start_ok ? PREFETCH : IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en         = 1'b0;
        rd_addr       = '0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        bus.ready     = (state == ACTIVE);
        bus.line_done = 1'b0;
        case (state)
            PREFETCH: rd_en = 1'b1;
            ACTIVE: begin
                if (take_pix) begin
                    wr_en   = (col != '0);
                    wr_addr = col - ADDR_BITS'(1);
                    wr_data = bus.err_bl_wr;
                    if (col != last_col) begin
                        rd_en   = 1'b1;
                        rd_addr = col + ADDR_BITS'(1);
                    end
                end
            end
            FLUSH: begin
                if (!bus.frame_start) begin
                    wr_en         = 1'b1;
                    wr_addr       = last_col;
                    wr_data       = b_last;
                    bus.line_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            first_line <= 1'b1;
            fresh_p1   <= 1'b0;
        end else begin
            fresh_p1 <= rd_en;
            if (bus.frame_start)    first_line <= 1'b1;
            else if (state == FLUSH) first_line <= 1'b0;
            if (state_nxt == PREFETCH)                 col <= '0;
            else if (take_pix && col != last_col)      col <= col + ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state_nxt == PREFETCH)           width_q <= width_clip;
        if (take_pix && col == last_col)     b_last  <= bus.err_b_wr;
    end

    // p1: RAM read/write (write address is always below the read address)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_p1   <= mem[rd_addr];
    end

    // p2: hold the last read word through stalls
    always_ff @(posedge clk) begin
        if (fresh_p1) hold_p2 <= rd_data_p1;
    end

    assign bus.err_rd = first_line ? err_t'(0) : (fresh_p1 ? rd_data_p1 : hold_p2);
endmodule

// File: tb/tb_error_line_buffer.sv
// Randomized bench for error_line_buffer: a column-indexed model of the stored
// row is compared with the DUT every cycle, plus literal read-back checks.
module tb_error_line_buffer;
    localparam int EB = 9;
    localparam int MW = 2048;
    localparam int AB = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    error_line_buffer_if #(.ERROR_BITS(EB), .ADDR_BITS(AB)) bus ();

    error_line_buffer #(.ERROR_BITS(EB), .MAX_WIDTH(MW), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic                 chk_en = 1'b0;
    logic                 exp_ready, exp_done, exp_echk;
    logic signed [EB-1:0] exp_err;

    // Reference: the stored row as an array, plus whether the next read is masked.
    logic signed [EB-1:0] mdl   [MW];
    bit                   known [MW];
    bit                   mdl_first;
    bit                   line_open;
    int                   open_col;

    logic signed [EB-1:0] bl_tab [16];
    logic signed [EB-1:0] b_tab;
    logic signed [EB-1:0] got    [16];
    logic signed [EB-1:0] a_tab  [16];
    logic signed [EB-1:0] a_b;
    logic signed [EB-1:0] b2_tab [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'b0, bus.ready}, {31'b0, exp_ready});
            check("line_done", {31'b0, bus.line_done}, {31'b0, exp_done});
            if (exp_echk) check("err_rd", {23'b0, bus.err_rd}, {23'b0, exp_err});
        end
    end

    function automatic logic signed [EB-1:0] rnd();
        logic [31:0] r;
        r = $urandom;
        return r[EB-1:0];
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) bl_tab[i] = rnd();
        b_tab = rnd();
    endtask

    task automatic exp_col(input int c, output logic ec, output logic signed [EB-1:0] ee);
        ec = mdl_first || known[c];
        ee = mdl_first ? '0 : mdl[c];
    endtask

    task automatic cyc(input logic fs, input logic ls, input int lw, input logic pv,
                       input logic signed [EB-1:0] bl, input logic signed [EB-1:0] bb,
                       input logic er, input logic ed, input logic ec,
                       input logic signed [EB-1:0] ee);
        bus.frame_start = fs;
        bus.line_start  = ls;
        bus.line_width  = AB'(lw);
        bus.pix_valid   = pv;
        bus.err_bl_wr   = bl;
        bus.err_b_wr    = bb;
        exp_ready = er;
        exp_done  = ed;
        exp_echk  = ec;
        exp_err   = ee;
        @(posedge clk); #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 0, 1'b0, rnd(), rnd(), 1'b0, 1'b0, mdl_first, '0);
    endtask

    task automatic frame_pulse();
        logic ec;
        logic signed [EB-1:0] ee;
        if (line_open) exp_col(open_col, ec, ee);
        else begin ec = mdl_first; ee = '0; end
        cyc(1'b1, 1'b0, 0, 1'b0, rnd(), rnd(), line_open, 1'b0, ec, ee);
        line_open = 0;
        mdl_first = 1;
        idle_cyc();
    endtask

    // One line: start, prefetch, w pixels with random gaps, flush. stop_at >= 0
    // leaves the line open after that many pixels (the next start aborts it).
    task automatic run_line(input int w, input int maxgap, input int stop_at,
                            input bit fs_start, input bit fs_flush);
        logic ec;
        logic signed [EB-1:0] ee, bl, bb, b_last;
        int gaps;
        b_last = '0;
        if (line_open) exp_col(open_col, ec, ee);
        else begin ec = mdl_first; ee = '0; end
        cyc(fs_start, 1'b1, w, 1'b0, rnd(), rnd(), line_open, 1'b0, ec, ee);
        line_open = 0;
        if (fs_start) mdl_first = 1;
        if (w == 0) begin
            idle_cyc();
            return;
        end
        cyc(1'b0, 1'b0, 0, 1'b0, rnd(), rnd(), 1'b0, 1'b0, mdl_first, '0);
        for (int c = 0; c < w; c++) begin
            if (c == stop_at) begin
                line_open = 1;
                open_col  = c;
                return;
            end
            gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            exp_col(c, ec, ee);
            repeat (gaps) cyc(1'b0, 1'b0, 0, 1'b0, rnd(), rnd(), 1'b1, 1'b0, ec, ee);
            bl = bl_tab[c];
            bb = (c == w - 1) ? b_tab : rnd();
            got[c] = bus.err_rd;
            cyc(1'b0, 1'b0, 0, 1'b1, bl, bb, 1'b1, 1'b0, ec, ee);
            if (c > 0) begin mdl[c-1] = bl; known[c-1] = 1; end
            if (c == w - 1) b_last = bb;
        end
        cyc(fs_flush, 1'b0, 0, 1'b0, rnd(), rnd(), 1'b0, !fs_flush, mdl_first, '0);
        if (fs_flush) mdl_first = 1;
        else begin
            mdl[w-1]   = b_last;
            known[w-1] = 1;
            mdl_first  = 0;
        end
        idle_cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, st;
        bit fs, ff;
        for (int i = 0; i < MW; i++) known[i] = 0;
        mdl_first = 1;
        line_open = 0;
        open_col  = 0;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.line_width  = '0;
        bus.pix_valid   = 1'b0;
        bus.err_bl_wr   = '0;
        bus.err_b_wr    = '0;
        rst       = 1'b1;
        exp_ready = 1'b0;
        exp_done  = 1'b0;
        exp_echk  = 1'b1;
        exp_err   = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cyc();

        // Basic row hand-off
        frame_pulse();
        for (int i = 0; i < 4; i++) bl_tab[i] = EB'(i + 1);
        b_tab = 9'sd9;
        run_line(4, 0, -1, 0, 0);
        fill_rand();
        run_line(4, 0, -1, 0, 0);
        check("lit_row1_c0", {23'b0, got[0]}, 32'd2);
        check("lit_row1_c1", {23'b0, got[1]}, 32'd3);
        check("lit_row1_c2", {23'b0, got[2]}, 32'd4);
        check("lit_row1_c3", {23'b0, got[3]}, 32'd9);

        // Negative words pass bit-exact
        bl_tab[0] = '0; bl_tab[1] = 9'h1FF; bl_tab[2] = 9'h100; b_tab = rnd();
        run_line(3, 0, -1, 0, 0);
        fill_rand();
        run_line(3, 0, -1, 0, 0);
        check("lit_neg1", {23'b0, got[0]}, 32'h1FF);
        check("lit_neg256", {23'b0, got[1]}, 32'h100);

        // Stalls
        fill_rand(); run_line(8, 0, -1, 0, 0);
        fill_rand(); run_line(8, 5, -1, 0, 0);
        fill_rand(); run_line(8, 5, -1, 0, 0);

        // Width 1 and width 0
        fill_rand(); b_tab = 9'sd7;
        run_line(1, 0, -1, 0, 0);
        fill_rand();
        run_line(1, 0, -1, 0, 0);
        check("lit_w1", {23'b0, got[0]}, 32'd7);
        run_line(0, 0, -1, 0, 0);
        idle_cyc();

        // Abort after 3 of 6 pixels
        fill_rand(); run_line(6, 0, -1, 0, 0);
        for (int i = 0; i < 16; i++) a_tab[i] = bl_tab[i];
        a_b = b_tab;
        fill_rand(); run_line(6, 0, 3, 0, 0);
        for (int i = 0; i < 16; i++) b2_tab[i] = bl_tab[i];
        fill_rand(); run_line(6, 1, -1, 0, 0);
        check("abort_c0", {23'b0, got[0]}, {23'b0, b2_tab[1]});
        check("abort_c1", {23'b0, got[1]}, {23'b0, b2_tab[2]});
        check("abort_c2", {23'b0, got[2]}, {23'b0, a_tab[3]});
        check("abort_c5", {23'b0, got[5]}, {23'b0, a_b});

        // frame_start mid-line, during flush, and together with line_start
        fill_rand(); run_line(5, 1, 2, 0, 0);
        frame_pulse();
        fill_rand(); run_line(5, 2, -1, 0, 0);
        for (int i = 0; i < 5; i++) check("zero_after_frame", {23'b0, got[i]}, 32'd0);
        fill_rand(); run_line(5, 0, -1, 0, 1);
        fill_rand(); run_line(5, 0, -1, 0, 0);
        fill_rand(); run_line(5, 0, -1, 1, 0);
        fill_rand(); run_line(5, 0, -1, 0, 0);

        // Random lines
        for (int n = 0; n < 40; n++) begin
            w  = int'($urandom_range(1, 12));
            st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, w - 1)) : -1;
            fs = ($urandom_range(0, 7) == 0);
            ff = (st < 0) && ($urandom_range(0, 7) == 0);
            fill_rand();
            run_line(w, 3, st, fs, ff);
            if (!line_open && $urandom_range(0, 9) == 0) frame_pulse();
        end
        if (line_open) frame_pulse();
        idle_cyc();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
